wrr_arbiter: RTL and testbench
==============================

// Module: wrr_arbiter
// PURPOSE
//   Parametrised weighted round-robin arbiter for NUM_REQ requesters with a registered one-hot grant.
//   Each requester has a programmable weight: once granted, it keeps the grant for up to that many
//   consecutive cycles while it keeps requesting, then priority rotates past it.
//   Sits between request sources and a shared resource (bus, memory port, output queue).
// PARAMETERS
//   NUM_REQ   4  number of requesters (>=2)
//   WEIGHT_W  3  width of each per-requester weight field
// PORTS
//   clk        input   1                  clock, all logic rising-edge
//   rst        input   1                  synchronous, active-high reset
//   req        input   NUM_REQ            request vector, bit i = requester i
//   weight     input   NUM_REQ*WEIGHT_W   weight[i*WEIGHT_W +: WEIGHT_W] = max consecutive grant cycles for i
//   gnt        output  NUM_REQ            registered one-hot grant, all-zero when idle
//   gnt_id     output  $clog2(NUM_REQ)    binary index of granted requester, 0 when idle
//   gnt_valid  output  1                  1 when gnt != 0
// BEHAVIOUR
//   - Reset (rst=1 at posedge): gnt=0, gnt_id=0, gnt_valid=0, ptr=0, burst counter=0, latched weight=0.
//   - rst has priority over everything; asserting it mid-burst clears gnt at that same edge.
//   - Registered outputs: req sampled at edge t drives gnt after edge t (1-cycle latency).
//   - Internal state:
//       ptr      highest-priority index, 0..NUM_REQ-1
//       owner    the current grant holder
//       cnt      cycles already granted in the current burst
//       wlat     owner's effective weight, latched at burst start
//   - Effective weight = weight field, except 0 is treated as 1. Weight is latched only at burst start;
//     changes to weight mid-burst take effect at the owner's next burst.
//   - Per-edge decision (rst=0):
//       HOLD when gnt_valid && req[owner] && (cnt+1 < wlat): gnt unchanged, cnt <= cnt+1, ptr unchanged.
//       Otherwise ARBITRATE:
//         scan req from ptr upward, wrapping modulo NUM_REQ; the first set bit k wins.
//         Winner: gnt <= 1<<k, gnt_id <= k, cnt <= 0, wlat <= eff_weight[k], ptr <= (k+1) mod NUM_REQ.
//         If req == 0: gnt <= 0, gnt_valid <= 0; ptr and cnt hold.
//   - Owner drops req mid-burst: burst ends at the next edge (ARBITRATE). Because ptr already points
//     past the owner, the owner has lowest priority in that arbitration.
//   - Owner exhausts its weight while others request: the grant moves to the next requester in rotation.
//     No idle cycle is inserted between bursts.
//   - Owner is the sole requester at burst end: it re-wins immediately (new burst, cnt=0). The grant
//     stays continuous with no gap.
//   - Wrap-around: after NUM_REQ-1 wins, ptr wraps to 0. Scan wraps from index NUM_REQ-1 to 0.
//   - Invariants: gnt is zero or one-hot; gnt bit set implies req for that bit was 1 at the prior edge;
//     cnt < wlat always.
//   - Fairness: with all requesting, each requester i is granted exactly eff_weight[i] cycles per rotation.
//   - Pure synchronous logic; no combinational path from req to gnt.
// TESTING (NUM_REQ=4, WEIGHT_W=3)
//   1. Reset: rst=1 for 2 cycles with req=4'b1111, weights all 1.
//      -> gnt=0000 and gnt_valid=0 throughout reset; first edge after release gives gnt=0001, gnt_id=0.
//   2. Equal weights: all weights 1, req=1111 held 8 cycles.
//      -> gnt = 0001,0010,0100,1000,0001,0010,0100,1000.
//   3. Weighted rotation: weights {w3=3,w2=2,w1=0,w0=1}, req=1111.
//      -> per rotation: 0001 x1, 0010 x1 (w=0 treated as 1), 0100 x2, 1000 x3; repeats.
//   4. Early release: w2=3, port 2 granted, req[2] drops after its first grant cycle, req[3]=1.
//      -> next edge gnt=1000; port 2 regains the grant only after port 3's burst (next rotation).
//   5. Single requester / idle: req=0100 with w2=2 for 6 cycles -> gnt=0100 continuously, no gap.
//      Then req=0000 -> gnt=0000, gnt_valid=0 next edge. Then req=1000 -> gnt=1000 one edge later.
//   6. Reset mid-burst: w3=3, pulse rst on the 2nd cycle of port 3's burst with req=1111.
//      -> gnt=0000 at that edge; after release gnt=0001 (ptr back to 0).

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with a registered one-hot grant.
// Once a requester wins, it keeps the grant for up to its weight in
// consecutive cycles while it keeps requesting. After that, priority
// rotates past it. A weight of 0 behaves as 1.
module wrr_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int WEIGHT_W = 3,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [ID_W-1:0]              gnt_id,
  output logic                         gnt_valid
);

  // Rotation pointer: the index that gets first look in the next arbitration.
  logic [ID_W-1:0]     ptr;
  // Number of cycles already granted in the current burst.
  logic [WEIGHT_W-1:0] cnt;
  // Owner's effective weight, captured when its burst starts.
  logic [WEIGHT_W-1:0] wlat;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  int                  scan_idx;
  logic [WEIGHT_W-1:0] win_field;
  logic [WEIGHT_W-1:0] win_eff;
  logic [ID_W-1:0]     ptr_next;
  logic                hold;

  // Scan requests from ptr upward, wrapping around; the first set bit wins.
  always_comb begin
    // NOTE: every variable in this block gets a default first. A path
    // that leaves a variable unassigned would infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = int'(ptr) + off;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(scan_idx);
      end
    end
  end

  // Winner's effective weight, its follow-on pointer, and the hold condition.
  always_comb begin
    win_field = weight[int'(win_id)*WEIGHT_W +: WEIGHT_W];
    win_eff   = (win_field == '0) ? WEIGHT_W'(1) : win_field;
    ptr_next  = (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
    hold      = gnt_valid && req[gnt_id] &&
                (({1'b0, cnt} + (WEIGHT_W+1)'(1)) < {1'b0, wlat});
  end

  // Grant register: reset, extend the burst, start a new burst, or go idle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together from their values before the edge.
    if (rst) begin
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      wlat      <= '0;
    end else if (hold) begin
      cnt <= cnt + 1'b1;
    end else if (win_found) begin
      gnt       <= NUM_REQ'(1) << win_id;
      gnt_id    <= win_id;
      gnt_valid <= 1'b1;
      cnt       <= '0;
      wlat      <= win_eff;
      ptr       <= ptr_next;
    end else begin
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed bench for wrr_arbiter (NUM_REQ=4, WEIGHT_W=3). Every expected
// grant value in this file was worked out by hand.
module tb_wrr_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int WEIGHT_W = 3;
  localparam int ID_W     = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic [NUM_REQ-1:0]          gnt;
  logic [ID_W-1:0]             gnt_id;
  logic                        gnt_valid;

  int n_checks = 0;
  int n_pass   = 0;

  wrr_arbiter #(.NUM_REQ(NUM_REQ), .WEIGHT_W(WEIGHT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .weight    (weight),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for the next rising edge, then step 1 ns past it to sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the whole grant bundle against one expected one-hot grant.
  task automatic expect_gnt(input string tag, input logic [NUM_REQ-1:0] g);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_REQ; i++) if (g[i]) id = ID_W'(i);
    check({tag, ".gnt"},   32'(gnt),       32'(g));
    check({tag, ".id"},    32'(gnt_id),    32'(id));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(g != '0));
  endtask

  // Hold rst for two edges, then release it.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [NUM_REQ*WEIGHT_W-1:0] wv(input int w3, input int w2,
                                                     input int w1, input int w0);
    return {WEIGHT_W'(w3), WEIGHT_W'(w2), WEIGHT_W'(w1), WEIGHT_W'(w0)};
  endfunction

  logic [NUM_REQ-1:0] exp2 [8]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NUM_REQ-1:0] exp3 [14] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100,
                                    4'b1000, 4'b1000, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b0100,
                                    4'b1000, 4'b1000, 4'b1000};
  logic [NUM_REQ-1:0] exp4 [6]  = '{4'b0001, 4'b0010, 4'b0100, 4'b0100,
                                    4'b0100, 4'b1000};

  initial begin
    rst    = 1'b1;
    req    = 4'b1111;
    weight = wv(1, 1, 1, 1);

    // 1. Reset: no grant while rst is held, then port 0 wins first.
    tick(); expect_gnt("rst_c0", 4'b0000);
    tick(); expect_gnt("rst_c1", 4'b0000);
    rst = 1'b0;
    tick(); expect_gnt("rst_rel", 4'b0001);

    // 2. Equal weights: plain round-robin.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(); expect_gnt($sformatf("eq%0d", i), exp2[i]);
    end

    // 3. Weighted rotation: w1 = 0 behaves as 1.
    weight = wv(3, 2, 0, 1);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(); expect_gnt($sformatf("wrr%0d", i), exp3[i]);
    end

    // 4. Early release: port 2 drops after one cycle and loses its place.
    weight = wv(1, 3, 1, 1);
    do_reset();
    tick(); expect_gnt("er_a", 4'b0001);
    tick(); expect_gnt("er_b", 4'b0010);
    tick(); expect_gnt("er_c", 4'b0100);
    req = 4'b1011;
    tick(); expect_gnt("er_drop", 4'b1000);
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick(); expect_gnt($sformatf("er_rot%0d", i), exp4[i]);
    end

    // 5. Single requester keeps the grant with no gap; then idle; then port 3.
    weight = wv(1, 2, 1, 1);
    req    = 4'b0100;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(); expect_gnt($sformatf("solo%0d", i), 4'b0100);
    end
    req = 4'b0000;
    tick(); expect_gnt("idle", 4'b0000);
    req = 4'b1000;
    tick(); expect_gnt("wake3", 4'b1000);

    // 6. Reset during port 3's burst clears the grant and the pointer.
    weight = wv(3, 1, 1, 1);
    req    = 4'b1111;
    do_reset();
    tick(); expect_gnt("mr_a", 4'b0001);
    tick(); expect_gnt("mr_b", 4'b0010);
    tick(); expect_gnt("mr_c", 4'b0100);
    tick(); expect_gnt("mr_d", 4'b1000);
    rst = 1'b1;
    tick(); expect_gnt("mr_rst", 4'b0000);
    rst = 1'b0;
    tick(); expect_gnt("mr_rel", 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
